idex_stage: RTL and testbench
=============================

// Module: idex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection. Captures decoded fields from ID each
//  cycle and presents them to EX and the forwarding unit (idexrs/idexrt/idexmemwr). When an ID/EX
//  load feeds the instruction in ID, it stalls PC and IF/ID and injects one bubble.
// PARAMETERS
//  DATA_W   32  operand/immediate width
//  RADDR_W  5   register-file address width
//  ALUOP_W  3   ALU control field width
//  CNT_W    16  stall/bubble performance counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        async active-low reset
//  hold         in   1        downstream freeze (EX/MEM busy): ID/EX contents unchanged
//  flush        in   1        branch/jump resolved taken: ID/EX becomes a bubble
//  id_valid     in   1        ID holds a real instruction
//  id_rs        in   RADDR_W  ID source register rs
//  id_rt        in   RADDR_W  ID source register rt
//  id_rd        in   RADDR_W  ID destination rd
//  id_uses_rt   in   1        ID instruction reads rt as an operand (R-type, sw, beq)
//  id_regdst    in   1        1: dest=rd, 0: dest=rt
//  id_regwr     in   1        register-file write enable
//  id_memrd     in   1        load
//  id_memwr     in   1        store
//  id_memtoreg  in   1        writeback from memory
//  id_alusrc    in   1        ALU B from immediate
//  id_aluop     in   ALUOP_W  ALU control
//  id_rdata1    in   DATA_W   register file port 1 data
//  id_rdata2    in   DATA_W   register file port 2 data
//  id_imm       in   DATA_W   sign-extended immediate
//  idexrs/idexrt/idexrd  out RADDR_W  registered register addresses
//  idexregdst, idexregwr, idexmemrd, idexmemwr, idexmemtoreg, idexalusrc  out 1  registered control
//  idexaluop    out  ALUOP_W  registered ALU control
//  idexrdata1/idexrdata2/ideximm  out DATA_W  registered operands
//  idexvalid    out  1        ID/EX holds a real instruction (0 = bubble)
//  pcwr         out  1        PC write enable (comb.)
//  ifidwr       out  1        IF/ID write enable (comb.)
//  stall_cnt    out  CNT_W    saturating count of load-use bubbles inserted
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registered outputs 0, stall_cnt 0; pcwr/ifidwr follow comb. rules.
//  - luh = idexvalid & idexmemrd & (idexrt!=0) & id_valid &
//          ((idexrt==id_rs) | (id_uses_rt & (idexrt==id_rt))).
//  - pcwr = ifidwr = ~(hold | luh). Combinational, same cycle as luh.
//  - Per rising edge, priority order:
//     1. flush=1: bubble (idexvalid, regwr, memrd, memwr, memtoreg = 0; other fields don't-care, driven 0).
//     2. hold=1: all ID/EX registers keep value; stall_cnt unchanged.
//     3. luh=1: bubble; stall_cnt += 1, saturating at all-ones.
//     4. else: capture all id_* fields; idexvalid=id_valid; if id_valid=0 control bits forced 0.
//  - Bubble lasts exactly one cycle: next cycle idexmemrd=0 so luh drops and ID instruction proceeds.
//  - Rs/rt of 0 never cause a stall. A store's rt dependency stalls only via id_uses_rt.
//  - flush and luh together: flush wins, stall_cnt not incremented, pcwr still 0 that cycle.
//  - Reset mid-stall: bubble discarded, pcwr/ifidwr return to 1 next evaluation.
// STRUCTURE
//  - Shared package: ALUOP_W, RADDR_W, DATA_W constants; typedef ctrl_t {regdst, regwr, memrd,
//    memwr, memtoreg, alusrc, aluop}; localparam CTRL_BUBBLE = '0.
//  - One sub-module: load_use_detect (pure comb., produces luh). Remaining logic is registers.
// TESTING
//  1. Reset: rst_n=0 with random id_* -> all outputs 0, stall_cnt=0; release -> first edge captures ID.
//  2. lw $2 in ID/EX, add $3,$2,$4 in ID -> pcwr=ifidwr=0 one cycle, idexvalid=0 next, stall_cnt=1, add captured after.
//  3. lw $0 in ID/EX, ID reads $0 -> no stall, pcwr=1.
//  4. lw $5 in ID/EX, ID addi (id_uses_rt=0, rt=5) -> no stall; sw rt=5 (id_uses_rt=1) -> stall.
//  5. flush=1 during luh -> ID/EX bubble, stall_cnt unchanged; hold=1 -> ID/EX stable, pcwr=0.
//  6. CNT_W=2, force 5 load-use stalls -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/idex_stage_pkg.sv
// ID/EX stage shared types and constants.
// Control bundle and the registered ID/EX record.
package idex_stage_pkg;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int ALUOP_W = 3;

  typedef struct packed {
    logic               regdst;
    logic               regwr;
    logic               memrd;
    logic               memwr;
    logic               memtoreg;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
    logic [RADDR_W-1:0] rd;
    ctrl_t              ctrl;
    logic [DATA_W-1:0]  rdata1;
    logic [DATA_W-1:0]  rdata2;
    logic [DATA_W-1:0]  imm;
  } id_ex_t;
endpackage

// File: rtl/idex_stage_if.sv
// ID-side decoded fields in, ID/EX registered fields out.
// slave: the stage itself; master: the ID/EX neighbours.
interface idex_stage_if;
  import idex_stage_pkg::*;

  logic               id_valid;
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;
  logic [RADDR_W-1:0] id_rd;
  logic               id_uses_rt;
  logic               id_regdst;
  logic               id_regwr;
  logic               id_memrd;
  logic               id_memwr;
  logic               id_memtoreg;
  logic               id_alusrc;
  logic [ALUOP_W-1:0] id_aluop;
  logic [DATA_W-1:0]  id_rdata1;
  logic [DATA_W-1:0]  id_rdata2;
  logic [DATA_W-1:0]  id_imm;

  logic [RADDR_W-1:0] idexrs;
  logic [RADDR_W-1:0] idexrt;
  logic [RADDR_W-1:0] idexrd;
  logic               idexregdst;
  logic               idexregwr;
  logic               idexmemrd;
  logic               idexmemwr;
  logic               idexmemtoreg;
  logic               idexalusrc;
  logic [ALUOP_W-1:0] idexaluop;
  logic [DATA_W-1:0]  idexrdata1;
  logic [DATA_W-1:0]  idexrdata2;
  logic [DATA_W-1:0]  ideximm;
  logic               idexvalid;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd,
    input  id_uses_rt, id_regdst, id_regwr,
    input  id_memrd, id_memwr, id_memtoreg,
    input  id_alusrc, id_aluop,
    input  id_rdata1, id_rdata2, id_imm,
    output idexrs, idexrt, idexrd,
    output idexregdst, idexregwr, idexmemrd,
    output idexmemwr, idexmemtoreg, idexalusrc,
    output idexaluop, idexrdata1, idexrdata2,
    output ideximm, idexvalid
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd,
    output id_uses_rt, id_regdst, id_regwr,
    output id_memrd, id_memwr, id_memtoreg,
    output id_alusrc, id_aluop,
    output id_rdata1, id_rdata2, id_imm,
    input  idexrs, idexrt, idexrd,
    input  idexregdst, idexregwr, idexmemrd,
    input  idexmemwr, idexmemtoreg, idexalusrc,
    input  idexaluop, idexrdata1, idexrdata2,
    input  ideximm, idexvalid
  );
endinterface

// File: rtl/idex_stage_load_use_detect.sv
// Load-use hazard: a load in ID/EX whose rt is read
// by the instruction in ID. Register 0 never stalls.
module load_use_detect
  import idex_stage_pkg::*;
(
  input  logic               i_ex_valid,
  input  logic               i_ex_memrd,
  input  logic [RADDR_W-1:0] i_ex_rt,
  input  logic               i_id_valid,
  input  logic [RADDR_W-1:0] i_id_rs,
  input  logic [RADDR_W-1:0] i_id_rt,
  input  logic               i_id_uses_rt,
  output logic               o_luh
);
  logic w_load;
  logic w_hit_rs;
  logic w_hit_rt;

  assign w_load   = i_ex_valid & i_ex_memrd &
                    (i_ex_rt != '0);
  assign w_hit_rs = (i_ex_rt == i_id_rs);
  assign w_hit_rt = i_id_uses_rt &
                    (i_ex_rt == i_id_rt);
  assign o_luh    = w_load & i_id_valid &
                    (w_hit_rs | w_hit_rt);
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall,
// one-cycle bubble injection and stall counter.
module idex_stage
  import idex_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  idex_stage_if.slave      bus,
  output logic             pcwr,
  output logic             ifidwr,
  output logic [CNT_W-1:0] stall_cnt
);
  id_ex_t           r_q;
  id_ex_t           w_cap;
  ctrl_t            w_ctrl;
  logic             w_luh;
  logic [CNT_W-1:0] r_cnt;

  load_use_detect u_lud (
    .i_ex_valid   (r_q.valid),
    .i_ex_memrd   (r_q.ctrl.memrd),
    .i_ex_rt      (r_q.rt),
    .i_id_valid   (bus.id_valid),
    .i_id_rs      (bus.id_rs),
    .i_id_rt      (bus.id_rt),
    .i_id_uses_rt (bus.id_uses_rt),
    .o_luh        (w_luh)
  );

  // Assemble the ID record; a non-instruction carries no control.
  always_comb begin
    w_ctrl.regdst   = bus.id_regdst;
    w_ctrl.regwr    = bus.id_regwr;
    w_ctrl.memrd    = bus.id_memrd;
    w_ctrl.memwr    = bus.id_memwr;
    w_ctrl.memtoreg = bus.id_memtoreg;
    w_ctrl.alusrc   = bus.id_alusrc;
    w_ctrl.aluop    = bus.id_aluop;
    w_cap.valid  = bus.id_valid;
    w_cap.rs     = bus.id_rs;
    w_cap.rt     = bus.id_rt;
    w_cap.rd     = bus.id_rd;
    w_cap.ctrl   = bus.id_valid ? w_ctrl
                                : CTRL_BUBBLE;
    w_cap.rdata1 = bus.id_rdata1;
    w_cap.rdata2 = bus.id_rdata2;
    w_cap.imm    = bus.id_imm;
  end

  // Pipeline register: flush > hold > bubble > capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (flush) begin
      r_q <= '0;
    end else if (!hold) begin
      r_q <= w_luh ? id_ex_t'('0) : w_cap;
    end
  end

  // Count only bubbles actually inserted; saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!flush && !hold && w_luh &&
                 (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign pcwr   = ~(hold | w_luh);
  assign ifidwr = ~(hold | w_luh);
  assign stall_cnt = r_cnt;

  assign bus.idexvalid    = r_q.valid;
  assign bus.idexrs       = r_q.rs;
  assign bus.idexrt       = r_q.rt;
  assign bus.idexrd       = r_q.rd;
  assign bus.idexregdst   = r_q.ctrl.regdst;
  assign bus.idexregwr    = r_q.ctrl.regwr;
  assign bus.idexmemrd    = r_q.ctrl.memrd;
  assign bus.idexmemwr    = r_q.ctrl.memwr;
  assign bus.idexmemtoreg = r_q.ctrl.memtoreg;
  assign bus.idexalusrc   = r_q.ctrl.alusrc;
  assign bus.idexaluop    = r_q.ctrl.aluop;
  assign bus.idexrdata1   = r_q.rdata1;
  assign bus.idexrdata2   = r_q.rdata2;
  assign bus.ideximm      = r_q.imm;
endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: spec-level model plus
// directed load-use, flush, hold and saturation cases.
module tb_idex_stage;
  import idex_stage_pkg::*;

  localparam ctrl_t C_LW   = 9'b0_1_1_0_1_1_000;
  localparam ctrl_t C_R    = 9'b1_1_0_0_0_0_010;
  localparam ctrl_t C_ADDI = 9'b0_1_0_0_0_1_000;
  localparam ctrl_t C_SW   = 9'b0_0_0_1_0_1_000;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic        pcwr0, ifidwr0;
  logic        pcwr1, ifidwr1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  id_ex_t t;
  logic   t_uses;
  id_ex_t m;
  int     mc0, mc1;
  int     checks = 0;
  int     errs   = 0;

  idex_stage_if if0 ();
  idex_stage_if if1 ();

  assign if0.id_valid    = t.valid;
  assign if0.id_rs       = t.rs;
  assign if0.id_rt       = t.rt;
  assign if0.id_rd       = t.rd;
  assign if0.id_uses_rt  = t_uses;
  assign if0.id_regdst   = t.ctrl.regdst;
  assign if0.id_regwr    = t.ctrl.regwr;
  assign if0.id_memrd    = t.ctrl.memrd;
  assign if0.id_memwr    = t.ctrl.memwr;
  assign if0.id_memtoreg = t.ctrl.memtoreg;
  assign if0.id_alusrc   = t.ctrl.alusrc;
  assign if0.id_aluop    = t.ctrl.aluop;
  assign if0.id_rdata1   = t.rdata1;
  assign if0.id_rdata2   = t.rdata2;
  assign if0.id_imm      = t.imm;
  assign if1.id_valid    = t.valid;
  assign if1.id_rs       = t.rs;
  assign if1.id_rt       = t.rt;
  assign if1.id_rd       = t.rd;
  assign if1.id_uses_rt  = t_uses;
  assign if1.id_regdst   = t.ctrl.regdst;
  assign if1.id_regwr    = t.ctrl.regwr;
  assign if1.id_memrd    = t.ctrl.memrd;
  assign if1.id_memwr    = t.ctrl.memwr;
  assign if1.id_memtoreg = t.ctrl.memtoreg;
  assign if1.id_alusrc   = t.ctrl.alusrc;
  assign if1.id_aluop    = t.ctrl.aluop;
  assign if1.id_rdata1   = t.rdata1;
  assign if1.id_rdata2   = t.rdata2;
  assign if1.id_imm      = t.imm;

  idex_stage #(.CNT_W(16)) u0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .flush     (flush),
    .bus       (if0.slave),
    .pcwr      (pcwr0),
    .ifidwr    (ifidwr0),
    .stall_cnt (cnt0)
  );

  idex_stage #(.CNT_W(2)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .flush     (flush),
    .bus       (if1.slave),
    .pcwr      (pcwr1),
    .ifidwr    (ifidwr1),
    .stall_cnt (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic mluh();
    logic dep;
    dep = (m.rt == t.rs) ||
          (t_uses && (m.rt == t.rt));
    return m.valid && m.ctrl.memrd &&
           (m.rt != 0) && t.valid && dep;
  endfunction

  // Reference model of the ID/EX contents and counters.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '0;
      mc0 <= 0;
      mc1 <= 0;
    end else if (flush) begin
      m <= '0;
    end else if (!hold) begin
      if (mluh()) begin
        m   <= '0;
        mc0 <= (mc0 == 65535) ? mc0 : mc0 + 1;
        mc1 <= (mc1 == 3) ? mc1 : mc1 + 1;
      end else begin
        m <= t;
        if (!t.valid) m.ctrl <= '0;
      end
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    logic ep;
    ep = !(hold || mluh());
    chk("valid",  32'(if0.idexvalid),    32'(m.valid));
    chk("rs",     32'(if0.idexrs),       32'(m.rs));
    chk("rt",     32'(if0.idexrt),       32'(m.rt));
    chk("rd",     32'(if0.idexrd),       32'(m.rd));
    chk("regdst", 32'(if0.idexregdst),   32'(m.ctrl.regdst));
    chk("regwr",  32'(if0.idexregwr),    32'(m.ctrl.regwr));
    chk("memrd",  32'(if0.idexmemrd),    32'(m.ctrl.memrd));
    chk("memwr",  32'(if0.idexmemwr),    32'(m.ctrl.memwr));
    chk("m2r",    32'(if0.idexmemtoreg), 32'(m.ctrl.memtoreg));
    chk("alusrc", 32'(if0.idexalusrc),   32'(m.ctrl.alusrc));
    chk("aluop",  32'(if0.idexaluop),    32'(m.ctrl.aluop));
    chk("rdata1", if0.idexrdata1,        m.rdata1);
    chk("rdata2", if0.idexrdata2,        m.rdata2);
    chk("imm",    if0.ideximm,           m.imm);
    chk("pcwr",   32'(pcwr0),            32'(ep));
    chk("ifidwr", 32'(ifidwr0),          32'(ep));
    chk("cnt",    32'(cnt0),             32'(mc0));
    chk("pcwr2",  32'(pcwr1),            32'(ep));
    chk("cnt2",   32'(cnt1),             32'(mc1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setid(input logic v,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] rd,
                       input logic u,
                       input ctrl_t c);
    t.valid  = v;
    t.rs     = rs;
    t.rt     = rt;
    t.rd     = rd;
    t_uses   = u;
    t.ctrl   = c;
    t.rdata1 = 32'h100 + 32'(rs);
    t.rdata2 = 32'h200 + 32'(rt);
    t.imm    = 32'hFFFF_FFF0 + 32'(rd);
  endtask

  task automatic lw(input logic [4:0] rt,
                    input logic [4:0] rs);
    setid(1'b1, rs, rt, 5'd0, 1'b0, C_LW);
  endtask

  task automatic rr(input logic [4:0] rd,
                    input logic [4:0] rs,
                    input logic [4:0] rt);
    setid(1'b1, rs, rt, rd, 1'b1, C_R);
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    t.valid  = 1'b1;
    t.rs     = 5'($urandom);
    t.rt     = 5'($urandom);
    t.rd     = 5'($urandom);
    t_uses   = 1'b1;
    t.ctrl   = ctrl_t'(9'($urandom));
    t.rdata1 = $urandom;
    t.rdata2 = $urandom;
    t.imm    = $urandom;
    tick();
    tick();
    chk("rst_valid", 32'(if0.idexvalid), 32'd0);
    chk("rst_d1",    if0.idexrdata1,     32'd0);
    chk("rst_cnt",   32'(cnt0),          32'd0);
    chk("rst_pcwr",  32'(pcwr0),         32'd1);
    lw(5'd7, 5'd1);
    rst_n = 1'b1;
    tick();
    chk("cap_valid", 32'(if0.idexvalid), 32'd1);
    chk("cap_rt",    32'(if0.idexrt),    32'd7);
    chk("cap_imm",   if0.ideximm,        32'hFFFF_FFF0);

    lw(5'd2, 5'd1);
    tick();
    rr(5'd3, 5'd2, 5'd4);
    #1;
    chk("lu_pcwr",   32'(pcwr0),         32'd0);
    chk("lu_ifidwr", 32'(ifidwr0),       32'd0);
    tick();
    chk("bub_valid", 32'(if0.idexvalid), 32'd0);
    chk("bub_cnt",   32'(cnt0),          32'd1);
    chk("bub_pcwr",  32'(pcwr0),         32'd1);
    tick();
    chk("add_rd",    32'(if0.idexrd),    32'd3);
    chk("add_valid", 32'(if0.idexvalid), 32'd1);

    lw(5'd0, 5'd1);
    tick();
    rr(5'd3, 5'd0, 5'd0);
    #1;
    chk("r0_pcwr", 32'(pcwr0), 32'd1);
    tick();

    lw(5'd5, 5'd1);
    tick();
    setid(1'b1, 5'd6, 5'd5, 5'd0, 1'b0, C_ADDI);
    #1;
    chk("addi_pcwr", 32'(pcwr0), 32'd1);
    tick();
    lw(5'd5, 5'd1);
    tick();
    setid(1'b1, 5'd6, 5'd5, 5'd0, 1'b1, C_SW);
    #1;
    chk("sw_pcwr", 32'(pcwr0), 32'd0);
    tick();
    tick();
    chk("sw_memwr", 32'(if0.idexmemwr), 32'd1);
    chk("sw_cnt",   32'(cnt0),          32'd2);

    lw(5'd8, 5'd1);
    tick();
    rr(5'd9, 5'd8, 5'd2);
    flush = 1'b1;
    #1;
    chk("fl_pcwr", 32'(pcwr0), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(if0.idexvalid), 32'd0);
    chk("fl_cnt",   32'(cnt0),          32'd2);
    tick();
    hold = 1'b1;
    rr(5'd12, 5'd13, 5'd14);
    #1;
    chk("hd_pcwr", 32'(pcwr0), 32'd0);
    tick();
    tick();
    chk("hd_rd", 32'(if0.idexrd), 32'd9);
    hold = 1'b0;
    setid(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, C_R);
    tick();
    chk("inv_regwr", 32'(if0.idexregwr), 32'd0);
    chk("inv_rd",    32'(if0.idexrd),    32'd5);

    for (int i = 0; i < 3; i++) begin
      lw(5'd10, 5'd1);
      tick();
      rr(5'd11, 5'd10, 5'd3);
      tick();
      tick();
    end
    chk("sat_cnt16", 32'(cnt0), 32'd5);
    chk("sat_cnt2",  32'(cnt1), 32'd3);

    lw(5'd11, 5'd1);
    tick();
    rr(5'd4, 5'd11, 5'd0);
    #1;
    chk("mr_pcwr0", 32'(pcwr0), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_pcwr1", 32'(pcwr0),         32'd1);
    chk("mr_valid", 32'(if0.idexvalid), 32'd0);
    chk("mr_cnt",   32'(cnt0),          32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errs);
    $finish;
  end
endmodule
